lc3_regfile_sb: RTL and testbench
=================================

Name: lc3_regfile_sb

Overview:
Parametrised general-purpose register file for the LC-3 datapath. It generalises the fixed 8x16, 2-read file in data width, register count and read-port count. It adds a per-register scoreboard for pending writes and an NZP condition-code register. It sits between the bus (writeback source) and the ALU/address-adder operand muxes, and the control FSM uses it to stall on read-after-write hazards.

Parameters:
DATA_WIDTH, 16, width of each register and of bus_data
NUM_REGS, 8, number of registers (power of two, >=2); ADDR_W = $clog2(NUM_REGS) derived localparam
NUM_RD, 2, number of independent read ports (>=1)
RESET_VALUE, 0, value loaded into every register on reset

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
ld_reg  in  1  write enable for register dr
dr  in  ADDR_W  destination register address
bus_data  in  DATA_WIDTH  write data, also the CC source
ld_cc  in  1  load NZP from bus_data
rd_addr  in  NUM_RD*ADDR_W  packed read addresses, port k at [k*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_WIDTH  packed read data, port k at [k*DATA_WIDTH +: DATA_WIDTH]
rd_busy  out  NUM_RD  port k's register has a pending claimed write
claim_valid  in  1  request to reserve claim_addr for a future write
claim_addr  in  ADDR_W  register to reserve
claim_ready  out  1  claim accepted this cycle when claim_valid=1
busy_vec  out  NUM_REGS  scoreboard bit per register
busy_count  out  ADDR_W+1  number of set busy bits
nzp  out  3  condition codes {N,Z,P}

Behaviour:
- Reset (synchronous, reset=1 at a rising edge):
  - All registers <= RESET_VALUE.
  - busy_vec <= 0 and busy_count <= 0.
  - nzp <= 3'b010.
  - Reset overrides ld_reg, ld_cc and claims in the same cycle.
  - A claim presented while reset=1 is dropped.
- Write: if ld_reg=1 at a rising edge, reg[dr] <= bus_data. Visible on rd_data the next cycle (1-cycle write latency). Writing a non-busy register is legal and leaves busy unchanged.
- Read: combinational. rd_data[k] = reg[rd_addr[k]] and rd_busy[k] = busy_vec[rd_addr[k]]. Ports are fully independent; identical addresses on several ports are legal.
- Scoreboard:
  - claim_ready = ~busy_vec[claim_addr] | (ld_reg & dr==claim_addr). It is combinational and independent of claim_valid.
  - Accept = claim_valid & claim_ready; on accept, busy[claim_addr] <= 1.
  - ld_reg=1 clears busy[dr].
  - If a write to X and an accepted claim of X occur in the same cycle, the data is written and busy[X] stays 1 (set wins).
  - A claim of an already-busy X with no same-cycle write is refused (claim_ready=0) and state is unchanged.
  - busy_count is registered and always equals the popcount of busy_vec. It updates in the same edge as busy_vec and never exceeds NUM_REGS.
- Condition codes: if ld_cc=1, nzp <= {bus_data[MSB], bus_data==0, ~bus_data[MSB] & bus_data!=0}. Exactly one bit is ever set. ld_cc is independent of ld_reg.

Optional Feature:
REG_FILE_BYPASS_EN:
- Defined: write-through forwarding. If ld_reg=1 and dr==rd_addr[k], then in that same cycle rd_data[k]=bus_data and rd_busy[k]=0.
- Undefined: reads return the stored value and the busy bit until the edge (plain 1-cycle latency).

Decomposition:
- Package lc3_regfile_pkg:
  - nzp_t (logic [2:0]).
  - Constants CC_N=3'b100, CC_Z=3'b010, CC_P=3'b001.
  - Function calc_nzp(data) parametrised through DATA_WIDTH.
- Storage: a generate loop of NUM_REGS instances of the existing load_reg (DATA_WIDTH param; clk, reset, load, data_i, data_q).
  - load = ld_reg & (dr==i).
  - data_i = bus_data.
- Scoreboard, busy_count and nzp live in the top module.

Test Plan:
- Reset, then read all regs on both ports -> each 16'h0000, busy_vec=0, busy_count=0, nzp=3'b010.
- ld_reg=1, dr=3, bus_data=16'hBEEF -> next cycle rd_addr[0]=3 gives 16'hBEEF; ld_cc with bus_data=16'h8000 -> nzp=100, with 0 -> 010, with 16'h0001 -> 001.
- claim R5 (accepted), then claim R5 again -> claim_ready=0, busy_count stays 1; rd_busy=1 on a port reading 5; write R5=16'h1234 -> busy clears, busy_count=0, data 16'h1234.
- Same cycle: write R2 while claiming R2 with R2 busy -> claim_ready=1, R2 data updated, busy[2] stays 1, busy_count unchanged.
- Claim all 8 registers over 8 cycles -> busy_count=8, busy_vec=8'hFF; assert reset with a pending claim -> all cleared, claim dropped.
- With REG_FILE_BYPASS_EN: write R1=16'h00AA while reading R1 -> rd_data=16'h00AA and rd_busy=0 in the same cycle. Without it -> old value in the same cycle, new value next cycle.

Source files
------------

// File: rtl/lc3_regfile_pkg.sv
// lc3_regfile_pkg
// Shared types, condition-code constants and the NZP helper for the LC-3
// register file with scoreboard.
//   nzp_t      : 3-bit {N,Z,P} condition-code value
//   CC_N/Z/P   : one-hot condition-code encodings
//   calc_nzp() : derives NZP from a zero-extended data word and its MSB index
package lc3_regfile_pkg;

  typedef logic [2:0] nzp_t;

  localparam nzp_t CC_N = 3'b100;
  localparam nzp_t CC_Z = 3'b010;
  localparam nzp_t CC_P = 3'b001;

  // Widest data word calc_nzp can classify; callers zero-extend into it.
  localparam int CC_MAX_W = 64;

  // The data word must be zero-extended above msb_idx so the zero test is
  // exact. The result is always one-hot: zero wins, then sign, else positive.
  function automatic nzp_t calc_nzp(input logic [CC_MAX_W-1:0] data,
                                    input logic [5:0]          msb_idx);
    logic sign_s;
    logic zero_s;
    nzp_t cc_s;
    sign_s = data[msb_idx];
    zero_s = (data == {CC_MAX_W{1'b0}});
    if (zero_s) begin
      cc_s = CC_Z;
    end else if (sign_s) begin
      cc_s = CC_N;
    end else begin
      cc_s = CC_P;
    end
    return cc_s;
  endfunction

endpackage

// File: rtl/load_reg.sv
// load_reg
// Single loadable register with synchronous active-high reset.
//   clk    : clock, rising edge
//   reset  : synchronous active-high reset, loads RESET_VALUE
//   load   : capture data_i at the next rising edge
//   data_i : write data
//   data_q : registered value
module load_reg #(
  parameter int                    DATA_WIDTH  = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_q
);

  logic [DATA_WIDTH-1:0] value_r;

  // Storage: reset has priority over load.
  always_ff @(posedge clk) begin
    if (reset) begin
      value_r <= RESET_VALUE;
    end else if (load) begin
      value_r <= data_i;
    end else begin
      value_r <= value_r;
    end
  end

  assign data_q = value_r;

endmodule

// File: rtl/lc3_regfile_sb.sv
// lc3_regfile_sb
// Parametrised LC-3 general-purpose register file with a per-register
// write scoreboard and the NZP condition-code register.
//   clk, reset   : clock and synchronous active-high reset
//   ld_reg, dr   : write enable and destination for bus_data
//   bus_data     : writeback data, also the condition-code source
//   ld_cc        : load nzp from bus_data
//   rd_addr      : packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_data      : packed read data, port k at [k*DATA_WIDTH +: DATA_WIDTH]
//   rd_busy      : per-port busy bit of the addressed register
//   claim_valid, claim_addr, claim_ready : reserve a register for a future write
//   busy_vec     : scoreboard, one bit per register
//   busy_count   : popcount of busy_vec (registered)
//   nzp          : condition codes {N,Z,P}
// Optional macro REG_FILE_BYPASS_EN: forwards a same-cycle write to the read
// ports (data = bus_data, busy = 0). Undefined: plain 1-cycle write latency.
module lc3_regfile_sb
  import lc3_regfile_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 16,
  parameter int                    NUM_REGS    = 8,
  parameter int                    NUM_RD      = 2,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  localparam int                   ADDR_W      = $clog2(NUM_REGS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ld_reg,
  input  logic [ADDR_W-1:0]            dr,
  input  logic [DATA_WIDTH-1:0]        bus_data,
  input  logic                         ld_cc,
  input  logic [NUM_RD*ADDR_W-1:0]     rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]            rd_busy,
  input  logic                         claim_valid,
  input  logic [ADDR_W-1:0]            claim_addr,
  output logic                         claim_ready,
  output logic [NUM_REGS-1:0]          busy_vec,
  output logic [ADDR_W:0]              busy_count,
  output logic [2:0]                   nzp
);

  logic [DATA_WIDTH-1:0] reg_q_s [NUM_REGS];

  logic [NUM_REGS-1:0]   busy_r;
  logic [NUM_REGS-1:0]   busy_next_s;
  logic [ADDR_W:0]       busy_count_r;
  logic [ADDR_W:0]       count_next_s;
  nzp_t                  nzp_r;
  logic                  claim_ready_s;
  logic                  accept_s;
  logic [CC_MAX_W-1:0]   cc_src_s;

  // ---------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    logic load_s;
    assign load_s = ld_reg & (dr == ADDR_W'(gi));

    load_reg #(
      .DATA_WIDTH  (DATA_WIDTH),
      .RESET_VALUE (RESET_VALUE)
    ) u_reg (
      .clk    (clk),
      .reset  (reset),
      .load   (load_s),
      .data_i (bus_data),
      .data_q (reg_q_s[gi])
    );
  end

  // ---------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------
  for (genvar gk = 0; gk < NUM_RD; gk++) begin : g_rd
    logic [ADDR_W-1:0]     addr_s;
    logic [DATA_WIDTH-1:0] data_s;
    logic                  busy_s;

    assign addr_s = rd_addr[gk*ADDR_W +: ADDR_W];

    // Read mux for one port, optionally forwarding the write in flight.
    always_comb begin
      data_s = reg_q_s[addr_s];
      busy_s = busy_r[addr_s];
`ifdef REG_FILE_BYPASS_EN
      if (ld_reg && (dr == addr_s)) begin
        data_s = bus_data;
        busy_s = 1'b0;
      end else begin
        data_s = reg_q_s[addr_s];
        busy_s = busy_r[addr_s];
      end
`endif
    end

    assign rd_data[gk*DATA_WIDTH +: DATA_WIDTH] = data_s;
    assign rd_busy[gk]                          = busy_s;
  end

  // ---------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------
  // Claim arbitration and next-state scoreboard; a same-cycle claim of the
  // register being written is accepted and its set overrides the clear.
  always_comb begin
    claim_ready_s = ~busy_r[claim_addr] | (ld_reg & (dr == claim_addr));
    accept_s      = claim_valid & claim_ready_s;
    busy_next_s   = busy_r;
    if (ld_reg) begin
      busy_next_s[dr] = 1'b0;
    end else begin
      busy_next_s = busy_r;
    end
    if (accept_s) begin
      busy_next_s[claim_addr] = 1'b1;
    end else begin
      busy_next_s = busy_next_s;
    end
  end

  // Popcount of the next scoreboard so busy_count tracks busy_vec exactly.
  always_comb begin
    count_next_s = {(ADDR_W+1){1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      count_next_s = count_next_s + (ADDR_W+1)'(busy_next_s[i]);
    end
  end

  assign cc_src_s = CC_MAX_W'(bus_data);

  // Scoreboard, busy count and condition-code state.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r       <= {NUM_REGS{1'b0}};
      busy_count_r <= {(ADDR_W+1){1'b0}};
      nzp_r        <= CC_Z;
    end else begin
      busy_r       <= busy_next_s;
      busy_count_r <= count_next_s;
      if (ld_cc) begin
        nzp_r <= calc_nzp(cc_src_s, 6'(DATA_WIDTH - 1));
      end else begin
        nzp_r <= nzp_r;
      end
    end
  end

  assign claim_ready = claim_ready_s;
  assign busy_vec    = busy_r;
  assign busy_count  = busy_count_r;
  assign nzp         = nzp_r;

endmodule

// File: tb/tb_lc3_regfile_sb.sv
module tb_lc3_regfile_sb;

  localparam int DW  = 16;
  localparam int NR  = 8;
  localparam int NRD = 2;
  localparam int AW  = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              ld_reg;
  logic [AW-1:0]     dr;
  logic [DW-1:0]     bus_data;
  logic              ld_cc;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic              claim_valid;
  logic [AW-1:0]     claim_addr;
  logic              claim_ready;
  logic [NR-1:0]     busy_vec;
  logic [AW:0]       busy_count;
  logic [2:0]        nzp;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q[$];
  logic [NR-1:0] m_busy;

  always #5 clk = ~clk;

  lc3_regfile_sb #(
    .DATA_WIDTH  (DW),
    .NUM_REGS    (NR),
    .NUM_RD      (NRD),
    .RESET_VALUE (16'h0000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ld_reg      (ld_reg),
    .dr          (dr),
    .bus_data    (bus_data),
    .ld_cc       (ld_cc),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_busy     (rd_busy),
    .claim_valid (claim_valid),
    .claim_addr  (claim_addr),
    .claim_ready (claim_ready),
    .busy_vec    (busy_vec),
    .busy_count  (busy_count),
    .nzp         (nzp)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp_v;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL %s: observed=%h but no expected value queued", tag, obs);
    end else begin
      exp_v = exp_q.pop_front();
      assert (obs === exp_v) else begin
        bad++;
        $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
      end
    end
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  initial begin
    reset = 1'b1; ld_reg = 1'b0; dr = 3'd0; bus_data = 16'h0000; ld_cc = 1'b0;
    rd_addr = 6'd0; claim_valid = 1'b0; claim_addr = 3'd0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state on both ports
    for (int r = 0; r < NR; r++) begin
      set_rd(AW'(r), AW'(NR - 1 - r));
      #1;
      push(32'h0000); check("rst_rd0", 32'(rd_data[15:0]));
      push(32'h0000); check("rst_rd1", 32'(rd_data[31:16]));
    end
    push(32'h00); check("rst_busy_vec", 32'(busy_vec));
    push(32'h0);  check("rst_busy_count", 32'(busy_count));
    push(32'h2);  check("rst_nzp", 32'(nzp));

    // Write R3 and read it back next cycle
    ld_reg = 1'b1; dr = 3'd3; bus_data = 16'hBEEF;
    tick();
    ld_reg = 1'b0; bus_data = 16'h0000;
    set_rd(3'd3, 3'd0);
    #1;
    push(32'hBEEF); check("wr_r3", 32'(rd_data[15:0]));
    push(32'h0000); check("r0_untouched", 32'(rd_data[31:16]));

    // Condition codes (ld_cc without ld_reg must not write)
    ld_cc = 1'b1; bus_data = 16'h8000; tick();
    push(32'h4); check("nzp_neg", 32'(nzp));
    bus_data = 16'h0000; tick();
    push(32'h2); check("nzp_zero", 32'(nzp));
    bus_data = 16'h0001; tick();
    push(32'h1); check("nzp_pos", 32'(nzp));
    bus_data = 16'h7FFF; tick();
    push(32'h1); check("nzp_maxpos", 32'(nzp));
    ld_cc = 1'b0; bus_data = 16'hFFFF; tick();
    push(32'h1); check("nzp_hold", 32'(nzp));
    push(32'hBEEF); check("cc_no_write", 32'(rd_data[15:0]));

    // Claim R5, then a refused repeat claim
    claim_valid = 1'b1; claim_addr = 3'd5;
    #1;
    push(32'h1); check("claim5_ready", 32'(claim_ready));
    tick();
    push(32'h20); check("claim5_vec", 32'(busy_vec));
    push(32'h1);  check("claim5_cnt", 32'(busy_count));
    push(32'h0);  check("claim5_again_ready", 32'(claim_ready));
    tick();
    claim_valid = 1'b0;
    push(32'h20); check("claim5_again_vec", 32'(busy_vec));
    push(32'h1);  check("claim5_again_cnt", 32'(busy_count));
    set_rd(3'd3, 3'd5);
    #1;
    push(32'h1); check("rd_busy5", 32'(rd_busy[1]));
    push(32'h0); check("rd_busy3", 32'(rd_busy[0]));

    // Writeback to R5 clears busy
    ld_reg = 1'b1; dr = 3'd5; bus_data = 16'h1234;
    #1;
`ifdef REG_FILE_BYPASS_EN
    push(32'h0); check("wr5_busy_fwd", 32'(rd_busy[1]));
`else
    push(32'h1); check("wr5_busy_same_cycle", 32'(rd_busy[1]));
`endif
    tick();
    ld_reg = 1'b0;
    push(32'h00);   check("wr5_vec", 32'(busy_vec));
    push(32'h0);    check("wr5_cnt", 32'(busy_count));
    push(32'h1234); check("wr5_data", 32'(rd_data[31:16]));
    push(32'h0);    check("wr5_rd_busy", 32'(rd_busy[1]));

    // Same-cycle write and claim of busy R2: set wins
    claim_valid = 1'b1; claim_addr = 3'd2;
    tick();
    push(32'h04); check("claim2_vec", 32'(busy_vec));
    ld_reg = 1'b1; dr = 3'd2; bus_data = 16'h5555;
    #1;
    push(32'h1); check("wr_claim2_ready", 32'(claim_ready));
    tick();
    ld_reg = 1'b0; claim_valid = 1'b0;
    set_rd(3'd2, 3'd2);
    #1;
    push(32'h04);   check("wr_claim2_vec", 32'(busy_vec));
    push(32'h1);    check("wr_claim2_cnt", 32'(busy_count));
    push(32'h5555); check("wr_claim2_data0", 32'(rd_data[15:0]));
    push(32'h5555); check("wr_claim2_data1", 32'(rd_data[31:16]));

    // Claim every register in turn (R2 already busy)
    m_busy = 8'h04;
    claim_valid = 1'b1;
    for (int i = 0; i < NR; i++) begin
      claim_addr = AW'(i);
      #1;
      push(m_busy[i] ? 32'h0 : 32'h1); check("claim_all_ready", 32'(claim_ready));
      tick();
      m_busy[i] = 1'b1;
      push(32'(m_busy));             check("claim_all_vec", 32'(busy_vec));
      push(32'($countones(m_busy))); check("claim_all_cnt", 32'(busy_count));
    end
    claim_valid = 1'b0;

    // Reset overrides a write, a CC load and an acceptable claim
    reset = 1'b1; ld_reg = 1'b1; dr = 3'd4; bus_data = 16'hFFFF; ld_cc = 1'b1;
    claim_valid = 1'b1; claim_addr = 3'd4;
    tick();
    reset = 1'b0; ld_reg = 1'b0; ld_cc = 1'b0; claim_valid = 1'b0;
    set_rd(3'd4, 3'd3);
    #1;
    push(32'h00);   check("rst2_vec", 32'(busy_vec));
    push(32'h0);    check("rst2_cnt", 32'(busy_count));
    push(32'h2);    check("rst2_nzp", 32'(nzp));
    push(32'h0000); check("rst2_r4", 32'(rd_data[15:0]));
    push(32'h0000); check("rst2_r3", 32'(rd_data[31:16]));

    // claim_ready does not depend on claim_valid
    claim_valid = 1'b1; claim_addr = 3'd6;
    tick();
    claim_valid = 1'b0;
    #1;
    push(32'h0); check("ready_idle_busy6", 32'(claim_ready));
    ld_reg = 1'b1; dr = 3'd6; bus_data = 16'h0606;
    #1;
    push(32'h1); check("ready_idle_wr6", 32'(claim_ready));
    tick();
    ld_reg = 1'b0;
    push(32'h00); check("wr6_vec", 32'(busy_vec));

    // Write R1 while reading it: forwarding versus plain latency
    claim_valid = 1'b1; claim_addr = 3'd1;
    tick();
    claim_valid = 1'b0;
    set_rd(3'd1, 3'd6);
    ld_reg = 1'b1; dr = 3'd1; bus_data = 16'h00AA;
    #1;
`ifdef REG_FILE_BYPASS_EN
    push(32'h00AA); check("byp_data", 32'(rd_data[15:0]));
    push(32'h0);    check("byp_busy", 32'(rd_busy[0]));
`else
    push(32'h0000); check("nobyp_data", 32'(rd_data[15:0]));
    push(32'h1);    check("nobyp_busy", 32'(rd_busy[0]));
`endif
    push(32'h0606); check("r6_other_port", 32'(rd_data[31:16]));
    tick();
    ld_reg = 1'b0;
    push(32'h00AA); check("r1_next_cycle", 32'(rd_data[15:0]));
    push(32'h0);    check("r1_busy_next", 32'(rd_busy[0]));
    push(32'h0);    check("r1_cnt_next", 32'(busy_count));

    if (exp_q.size() != 0) begin
      bad++;
      $error("FAIL leftover_expect: observed=%0d entries expected=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
